// File: rtl/tx_eth_pad_fcs.sv
// Ethernet transmit tail stage: zero-pads short frames to 60 bytes and
// appends the IEEE 802.3 FCS (CRC-32, transmitted least significant byte first).
//
// state    | meaning
// ---------|-----------------------------------------------------------------
// PASS     | input beats flow straight through; the last beat gets the FCS/pad
// PAD      | input stalled, emitting all-zero pad beats; FCS in the final beat
// FCS_TAIL | input stalled, emitting the FCS bytes that did not fit the last beat
module tx_eth_pad_fcs #(
    parameter bit ENABLE_PAD = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] rx_tdata,
    input  logic [7:0]  rx_tkeep,
    input  logic        rx_tvalid,
    input  logic        rx_tlast,
    output logic        rx_tready,
    output logic [63:0] tx_tdata,
    output logic [7:0]  tx_tkeep,
    output logic        tx_tvalid,
    output logic        tx_tlast,
    input  logic        tx_tready
);

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        PASS     = 2'd0,
        PAD      = 2'd1,
        FCS_TAIL = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  beat_cnt, beat_cnt_nxt;
    logic [31:0] crc, crc_nxt;
    logic [31:0] fcs_r, fcs_nxt;
    // FCS bytes still owed after a last beat with more than 4 data bytes
    logic [2:0]  tail_n, tail_nxt;
    // Set once the frame has gone past 8 input beats, where beat_cnt saturates
    // and can no longer tell us the frame is already long enough.
    logic        long_frame, long_nxt;

    logic [3:0]  n_bytes;
    logic [7:0]  n_mask;
    logic [63:0] kept_data;
    logic [6:0]  frame_len;
    logic        no_pad;
    logic [63:0] crc_d;
    logic [7:0]  crc_m;
    logic [31:0] crc_calc;
    logic [31:0] fcs_calc;
    logic        hs;
    logic        frame_done;

    logic [63:0] data_o;
    logic [7:0]  keep_o;
    logic        last_o;
    logic        valid_o;
    logic        ready_o;

    function automatic logic [3:0] popcnt8(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        return cnt;
    endfunction

    function automatic logic [7:0] keep_mask(input logic [3:0] cnt);
        logic [7:0] m;
        m = 8'h00;
        for (int i = 0; i < 8; i++) begin
            m[i] = (4'(i) < cnt);
        end
        return m;
    endfunction

    // Byte-serial reflected CRC-32 over the enabled bytes, lowest byte first.
    function automatic logic [31:0] crc_bytes(input logic [31:0] c_in,
                                              input logic [63:0] d,
                                              input logic [7:0]  m);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                c = c ^ {24'h000000, d[8*i +: 8]};
                for (int j = 0; j < 8; j++) begin
                    c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
                end
            end
        end
        return c;
    endfunction

    // Every non-PASS state always presents a beat, so only PASS depends on rx_tvalid.
    assign hs = (state == PASS) ? (rx_tvalid & tx_tready) : tx_tready;

    // Decode the incoming beat: byte count, zeroed unused bytes, running frame length.
    always_comb begin
        n_bytes   = popcnt8(rx_tkeep);
        n_mask    = keep_mask(n_bytes);
        kept_data = 64'h0;
        for (int i = 0; i < 8; i++) begin
            kept_data[8*i +: 8] = n_mask[i] ? rx_tdata[8*i +: 8] : 8'h00;
        end
        frame_len = {1'b0, beat_cnt, 3'b000} + {3'b000, n_bytes};
        no_pad    = !ENABLE_PAD || long_frame || (frame_len >= 7'd60);
    end

    // Select which bytes of the emitted beat feed the CRC; FCS bytes never do.
    always_comb begin
        crc_d = 64'h0;
        crc_m = 8'h00;
        case (state)
            PASS: begin
                crc_d = kept_data;
                if (!rx_tlast || no_pad) begin
                    crc_m = n_mask;
                end else if (beat_cnt == 3'd7) begin
                    crc_m = 8'h0F;
                end else begin
                    crc_m = 8'hFF;
                end
            end
            PAD: begin
                crc_m = (beat_cnt == 3'd7) ? 8'h0F : 8'hFF;
            end
            default: begin
                crc_m = 8'h00;
            end
        endcase
        crc_calc = crc_bytes(crc, crc_d, crc_m);
        fcs_calc = ~crc_calc;
    end

    // Next-state and output beat construction.
    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        crc_nxt      = crc;
        fcs_nxt      = fcs_r;
        tail_nxt     = tail_n;
        long_nxt     = long_frame;
        frame_done   = 1'b0;
        valid_o      = 1'b0;
        ready_o      = 1'b0;
        data_o       = 64'h0;
        keep_o       = 8'h00;
        last_o       = 1'b0;

        case (state)
            PASS: begin
                valid_o = rx_tvalid;
                ready_o = tx_tready;
                if (!rx_tlast) begin
                    data_o = rx_tdata;
                    keep_o = rx_tkeep;
                    if (hs) begin
                        crc_nxt = crc_calc;
                        if (beat_cnt == 3'd7) begin
                            long_nxt = 1'b1;
                        end else begin
                            beat_cnt_nxt = beat_cnt + 3'd1;
                        end
                    end
                end else if (no_pad) begin
                    // FCS sits right after the last data byte; any overflow goes to FCS_TAIL.
                    data_o = kept_data | ({32'h0, fcs_calc} << {n_bytes, 3'b000});
                    if (n_bytes <= 4'd4) begin
                        keep_o = keep_mask(n_bytes + 4'd4);
                        last_o = 1'b1;
                        frame_done = hs;
                    end else begin
                        keep_o = 8'hFF;
                        if (hs) begin
                            fcs_nxt   = fcs_calc;
                            tail_nxt  = 3'(n_bytes - 4'd4);
                            state_nxt = FCS_TAIL;
                        end
                    end
                end else if (beat_cnt == 3'd7) begin
                    // Eighth beat of a short frame: pad to byte 59, FCS in the upper half.
                    data_o     = {fcs_calc, kept_data[31:0]};
                    keep_o     = 8'hFF;
                    last_o     = 1'b1;
                    frame_done = hs;
                end else begin
                    data_o = kept_data;
                    keep_o = 8'hFF;
                    if (hs) begin
                        crc_nxt      = crc_calc;
                        beat_cnt_nxt = beat_cnt + 3'd1;
                        state_nxt    = PAD;
                    end
                end
            end

            PAD: begin
                valid_o = 1'b1;
                keep_o  = 8'hFF;
                if (beat_cnt == 3'd7) begin
                    data_o     = {fcs_calc, 32'h0};
                    last_o     = 1'b1;
                    frame_done = hs;
                end else if (hs) begin
                    crc_nxt      = crc_calc;
                    beat_cnt_nxt = beat_cnt + 3'd1;
                end
            end

            FCS_TAIL: begin
                valid_o    = 1'b1;
                data_o     = {32'h0, fcs_r >> {3'd4 - tail_n, 3'b000}};
                keep_o     = keep_mask({1'b0, tail_n});
                last_o     = 1'b1;
                frame_done = hs;
            end

            default: begin
                state_nxt = PASS;
            end
        endcase

        if (frame_done) begin
            state_nxt    = PASS;
            beat_cnt_nxt = 3'd0;
            crc_nxt      = CRC_INIT;
            long_nxt     = 1'b0;
        end
    end

    // State and frame-context registers; a reset abandons any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= PASS;
            beat_cnt   <= 3'd0;
            crc        <= CRC_INIT;
            fcs_r      <= 32'h0;
            tail_n     <= 3'd0;
            long_frame <= 1'b0;
        end else begin
            state      <= state_nxt;
            beat_cnt   <= beat_cnt_nxt;
            crc        <= crc_nxt;
            fcs_r      <= fcs_nxt;
            tail_n     <= tail_nxt;
            long_frame <= long_nxt;
        end
    end

    // Outputs are forced quiet while reset is held.
    assign tx_tvalid = reset & valid_o;
    assign rx_tready = reset & ready_o;
    assign tx_tdata  = reset ? data_o : 64'h0;
    assign tx_tkeep  = reset ? keep_o : 8'h00;
    assign tx_tlast  = reset & last_o;

endmodule

// File: tb/tb_tx_eth_pad_fcs.sv
// Bench for tx_eth_pad_fcs: one padding and one non-padding instance share the
// stimulus; a scoreboard queue holds the expected output beats of each frame.
module tb_tx_eth_pad_fcs;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] rx_tdata;
    logic [7:0]  rx_tkeep;
    logic        rx_tvalid;
    logic        rx_tlast;
    logic        tx_tready;
    logic        sel_np;

    logic        rx_tvalid_p, rx_tvalid_np;
    logic        rx_tready_p, rx_tready_np;
    logic [63:0] tx_tdata_p, tx_tdata_np;
    logic [7:0]  tx_tkeep_p, tx_tkeep_np;
    logic        tx_tvalid_p, tx_tvalid_np;
    logic        tx_tlast_p, tx_tlast_np;

    logic        rx_tready_s;
    logic [63:0] tx_tdata_s;
    logic [7:0]  tx_tkeep_s;
    logic        tx_tvalid_s;
    logic        tx_tlast_s;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } exp_beat_t;

    exp_beat_t   exp_q[$];
    logic [7:0]  frm[128];
    logic [7:0]  obuf[160];
    int          checks = 0;
    int          failures = 0;
    logic        pad_watch = 1'b0;
    logic        toggle_en = 1'b0;

    always #5 clk = ~clk;

    assign rx_tvalid_p  = rx_tvalid & ~sel_np;
    assign rx_tvalid_np = rx_tvalid & sel_np;
    assign rx_tready_s  = sel_np ? rx_tready_np : rx_tready_p;
    assign tx_tdata_s   = sel_np ? tx_tdata_np  : tx_tdata_p;
    assign tx_tkeep_s   = sel_np ? tx_tkeep_np  : tx_tkeep_p;
    assign tx_tvalid_s  = sel_np ? tx_tvalid_np : tx_tvalid_p;
    assign tx_tlast_s   = sel_np ? tx_tlast_np  : tx_tlast_p;

    tx_eth_pad_fcs #(.ENABLE_PAD(1'b1)) dut (
        .clk(clk), .reset(reset),
        .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep), .rx_tvalid(rx_tvalid_p),
        .rx_tlast(rx_tlast), .rx_tready(rx_tready_p),
        .tx_tdata(tx_tdata_p), .tx_tkeep(tx_tkeep_p), .tx_tvalid(tx_tvalid_p),
        .tx_tlast(tx_tlast_p), .tx_tready(tx_tready)
    );

    tx_eth_pad_fcs #(.ENABLE_PAD(1'b0)) dut_np (
        .clk(clk), .reset(reset),
        .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep), .rx_tvalid(rx_tvalid_np),
        .rx_tlast(rx_tlast), .rx_tready(rx_tready_np),
        .tx_tdata(tx_tdata_np), .tx_tkeep(tx_tkeep_np), .tx_tvalid(tx_tvalid_np),
        .tx_tlast(tx_tlast_np), .tx_tready(tx_tready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic gen_frame(input int len);
        for (int i = 0; i < len; i++) frm[i] = 8'($urandom_range(0, 255));
    endtask

    // Expected output: frame bytes, zero pad to 60 (if enabled), FCS LSB first.
    task automatic push_expected(input int len, input bit pad_en);
        int          olen;
        logic [31:0] c;
        exp_beat_t   e;
        for (int i = 0; i < len; i++) obuf[i] = frm[i];
        olen = len;
        if (pad_en) begin
            while (olen < 60) begin
                obuf[olen] = 8'h00;
                olen++;
            end
        end
        c = 32'hFFFFFFFF;
        for (int i = 0; i < olen; i++) begin
            c = c ^ {24'h0, obuf[i]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        for (int j = 0; j < 4; j++) obuf[olen + j] = c[8*j +: 8];
        olen += 4;
        for (int b = 0; b * 8 < olen; b++) begin
            e.data = 64'h0;
            e.keep = 8'h00;
            for (int j = 0; j < 8; j++) begin
                if (b * 8 + j < olen) begin
                    e.data[8*j +: 8] = obuf[b*8 + j];
                    e.keep[j] = 1'b1;
                end
            end
            e.last = ((b + 1) * 8 >= olen);
            exp_q.push_back(e);
        end
    endtask

    // Drive a frame from frm[]; stop before beat index abort_at when abort_at >= 0.
    task automatic send_frame(input int len, input int abort_at);
        int nb;
        int cyc;
        bit got;
        nb = (len + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            if (abort_at >= 0 && b == abort_at) break;
            for (int j = 0; j < 8; j++) begin
                if (b * 8 + j < len) begin
                    rx_tdata[8*j +: 8] = frm[b*8 + j];
                    rx_tkeep[j] = 1'b1;
                end else begin
                    rx_tdata[8*j +: 8] = 8'hA5;
                    rx_tkeep[j] = 1'b0;
                end
            end
            rx_tlast  = (b == nb - 1);
            rx_tvalid = 1'b1;
            cyc = 0;
            got = 1'b0;
            while (!got && cyc < 300) begin
                @(negedge clk);
                got = rx_tready_s;
                @(posedge clk);
                #1;
                cyc++;
            end
            checks++;
            assert (got) else begin
                failures++;
                $error("FAIL rx_accept_timeout beat=%0d observed=%0d expected=1", b, got);
                break;
            end
        end
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 400) begin
            @(posedge clk);
            cyc++;
        end
        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL %s_drain observed=%0d beats pending expected=0", tag, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Pop and compare each output handshake; check hold-while-stalled and PAD backpressure.
    task automatic monitor();
        exp_beat_t   e;
        logic [63:0] m;
        logic        stall;
        logic [63:0] hd;
        logic [7:0]  hk;
        logic        hl;
        stall = 1'b0;
        hd = 64'h0;
        hk = 8'h00;
        hl = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("stall_valid", {63'h0, tx_tvalid_s}, 64'h1);
                    chk("stall_data", tx_tdata_s, hd);
                    chk("stall_keep_last", {55'h0, tx_tkeep_s, tx_tlast_s}, {55'h0, hk, hl});
                end
                if (pad_watch && tx_tvalid_s) chk("pad_rx_tready", {63'h0, rx_tready_s}, 64'h0);
                if (tx_tvalid_s && tx_tready) begin
                    checks++;
                    assert (exp_q.size() > 0) else begin
                        failures++;
                        $error("FAIL unexpected_beat observed=%h expected=none", tx_tdata_s);
                    end
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        for (int j = 0; j < 8; j++) m[8*j +: 8] = {8{e.keep[j]}};
                        chk("beat_data", tx_tdata_s & m, e.data);
                        chk("beat_keep", {56'h0, tx_tkeep_s}, {56'h0, e.keep});
                        chk("beat_last", {63'h0, tx_tlast_s}, {63'h0, e.last});
                        if (e.last) pad_watch = 1'b0;
                    end
                end
                stall = tx_tvalid_s && !tx_tready;
                hd = tx_tdata_s;
                hk = tx_tkeep_s;
                hl = tx_tlast_s;
            end
        end
    endtask

    task automatic toggler();
        forever begin
            @(posedge clk);
            #2;
            if (toggle_en) tx_tready = ~tx_tready;
        end
    endtask

    initial begin
        exp_beat_t e;
        int        lens[8] = '{1, 8, 56, 59, 60, 61, 66, 100};

        reset     = 1'b0;
        sel_np    = 1'b0;
        rx_tdata  = 64'hDEADBEEF01234567;
        rx_tkeep  = 8'hFF;
        rx_tvalid = 1'b1;
        rx_tlast  = 1'b1;
        tx_tready = 1'b1;
        fork
            monitor();
            toggler();
        join_none

        // Reset state: outputs quiet even with a valid input beat presented.
        repeat (2) @(negedge clk);
        chk("rst_tx_tvalid", {63'h0, tx_tvalid_p}, 64'h0);
        chk("rst_rx_tready", {63'h0, rx_tready_p}, 64'h0);
        chk("rst_tx_tdata", tx_tdata_p, 64'h0);
        chk("rst_np_valid_ready", {62'h0, tx_tvalid_np, rx_tready_np}, 64'h0);
        @(posedge clk);
        #1;
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;

        // No padding: "123456789" -> FCS 26 39 F4 CB right after byte 8.
        sel_np = 1'b1;
        for (int i = 0; i < 9; i++) frm[i] = 8'h31 + 8'(i);
        e.data = 64'h3837363534333231; e.keep = 8'hFF; e.last = 1'b0; exp_q.push_back(e);
        e.data = 64'h000000CBF4392639; e.keep = 8'h1F; e.last = 1'b1; exp_q.push_back(e);
        send_frame(9, -1);
        wait_drain("np_check9");

        // No padding: short frame and a frame whose FCS spills into an extra beat.
        gen_frame(3);
        push_expected(3, 1'b0);
        send_frame(3, -1);
        gen_frame(62);
        push_expected(62, 1'b0);
        send_frame(62, -1);
        wait_drain("np_misc");
        sel_np = 1'b0;

        // 42-byte frame padded to 60, then the same frame with tx_tready toggling.
        gen_frame(42);
        push_expected(42, 1'b1);
        send_frame(42, -1);
        wait_drain("pad42");
        toggle_en = 1'b1;
        push_expected(42, 1'b1);
        send_frame(42, -1);
        pad_watch = 1'b1;
        wait_drain("pad42_stall");
        toggle_en = 1'b0;
        tx_tready = 1'b1;
        pad_watch = 1'b0;
        @(posedge clk);
        #1;

        // 64 bytes: FCS in an extra 4-byte beat. 68 bytes: FCS fills the last beat.
        gen_frame(64);
        push_expected(64, 1'b1);
        send_frame(64, -1);
        wait_drain("len64");
        gen_frame(68);
        push_expected(68, 1'b1);
        send_frame(68, -1);
        wait_drain("len68");

        // Boundary lengths sent back to back.
        foreach (lens[i]) begin
            gen_frame(lens[i]);
            push_expected(lens[i], 1'b1);
            send_frame(lens[i], -1);
        end
        wait_drain("b2b");

        // Reset after beat 3 of a 100-byte frame; the partial frame gets no FCS.
        gen_frame(100);
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 8; j++) e.data[8*j +: 8] = frm[b*8 + j];
            e.keep = 8'hFF;
            e.last = 1'b0;
            exp_q.push_back(e);
        end
        send_frame(100, 4);
        reset     = 1'b0;
        rx_tdata  = 64'hFEEDFACECAFEF00D;
        rx_tkeep  = 8'hFF;
        rx_tvalid = 1'b1;
        @(negedge clk);
        chk("abort_tx_tvalid", {63'h0, tx_tvalid_p}, 64'h0);
        chk("abort_rx_tready", {63'h0, rx_tready_p}, 64'h0);
        chk("abort_tx_tdata", tx_tdata_p, 64'h0);
        chk("abort_keep_last", {55'h0, tx_tkeep_p, tx_tlast_p}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rx_tvalid = 1'b0;
        reset     = 1'b1;
        wait_drain("abort");
        for (int i = 0; i < 9; i++) frm[i] = 8'h31 + 8'(i);
        push_expected(9, 1'b1);
        send_frame(9, -1);
        wait_drain("after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tx_eth_pad_fcs.md
Name: tx_eth_pad_fcs

Overview:
Downstream stage of the UDP/IP transmit encapsulator. It takes complete Ethernet frames on a 64-bit AXI-Stream: destination MAC through the end of the UDP payload, with no FCS. It zero-pads frames shorter than 60 bytes, computes the IEEE 802.3 CRC-32 over all emitted frame bytes, and appends the 4-byte FCS. The output feeds the MAC/PCS transmit interface.

Parameters:
ENABLE_PAD, 1, 1 = pad frames to 60 bytes before the FCS; 0 = append the FCS only, with no padding.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
rx_tdata  input  64  frame data; byte 0 in [7:0]
rx_tkeep  input  8  contiguous LSB-first byte enables; all-ones on every non-last beat
rx_tvalid  input  1  input beat valid
rx_tlast  input  1  last beat of frame
rx_tready  output  1  input beat accepted
tx_tdata  output  64  frame data with padding and FCS
tx_tkeep  output  8  output byte enables
tx_tvalid  output  1  output beat valid
tx_tlast  output  1  last output beat (carries the last FCS byte)
tx_tready  input  1  downstream ready

Behaviour:
- Reset is asynchronous and active-low.
  - While reset is low: state=PASS, beat_cnt=0, crc=32'hFFFFFFFF, fcs_r=0.
  - While reset is low: tx_tvalid=0, rx_tready=0.
- CRC: reflected poly 0xEDB88320, init all-ones, final complement. It is updated byte-serially inside a single cycle over bytes enabled in the emitted beat, lowest byte first. FCS bytes are never included.
- FCS transmit order: FCS[7:0] is sent first, FCS[31:24] last.
- beat_cnt: 3-bit index of the current input beat within the frame. It increments on each accepted non-last beat, saturates at 7, and clears after the last output beat.
- For the last input beat: n = number of set bits in rx_tkeep (0..8), k = beat_cnt, L = 8k+n.
- States: PASS, PAD, FCS_TAIL.
- PASS state:
  - Zero-latency pass-through: tx_tvalid=rx_tvalid, rx_tready=tx_tready.
  - Non-last beats pass unchanged; crc updates on the handshake.
- Accepted last beat, case L>=60 or ENABLE_PAD=0:
  - If n<=4: bytes n..n+3 = FCS, tx_tkeep = (1<<(n+4))-1, tx_tlast=1. Return to PASS.
  - If n>4: bytes n..7 = low (8-n) FCS bytes, tx_tkeep=FF, tx_tlast=0. Store the FCS in fcs_r and go to FCS_TAIL.
- Accepted last beat, case L<60 and k==7 (so n<4):
  - Bytes n..3 = 0, bytes 4..7 = FCS computed over the padded bytes.
  - tx_tkeep=FF, tx_tlast=1. Return to PASS.
- Accepted last beat, case L<60 and k<7:
  - Bytes n..7 = 0, tx_tkeep=FF, tx_tlast=0.
  - crc is updated over all 8 bytes; go to PAD.
- PAD state:
  - rx_tready=0, tx_tvalid=1. Emit all-zero beats, tkeep=FF, and advance beat_cnt on the handshake.
  - At beat_cnt==7: bytes 0..3 = 0, bytes 4..7 = FCS, tlast=1, then go to PASS.
- FCS_TAIL state:
  - rx_tready=0, tx_tvalid=1.
  - Low (n-4) bytes = remaining FCS bytes from fcs_r; tx_tkeep = (1<<(n-4))-1; tlast=1. Go to PASS on the handshake.
- Padded frames always leave as exactly 8 beats (64 bytes) with a last tkeep of FF.
- Handshake rules:
  - While tx_tvalid=1 and tx_tready=0, tx_tdata, tx_tkeep and tx_tlast hold stable.
  - crc, beat_cnt and state change only on a tx handshake.
- Reset mid-frame: the partial frame is abandoned and no FCS is emitted. After reset release, the first accepted beat starts a new frame with crc re-initialised.
- A back-to-back new frame may be accepted in the cycle after the last output beat's handshake, with no idle cycle required.
- Input constraint: rx_tkeep must be contiguous. If rx_tkeep=0 on a last beat, it is treated as n=0 (FCS occupies bytes 0..3).

Test Plan:
- ENABLE_PAD=0, 9-byte frame "123456789" (beat0 full, beat1 tkeep=01) -> beat1 out: tdata[39:8] = bytes 26 39 F4 CB, tkeep=1F, tlast=1.
- 42-byte frame (5 full beats + tkeep=03) -> 8 output beats; bytes 42..59 zero; last beat tkeep=FF, tlast=1; FCS matches the software CRC of the 60 padded bytes.
- 64-byte frame (8 full beats) -> last input beat out with tkeep=FF, tlast=0, then an extra beat with tkeep=0F, tlast=1 carrying the FCS.
- 68-byte frame (last tkeep=0F) -> last beat tkeep=FF, bytes 4..7 = FCS, tlast=1, no extra beat.
- 42-byte frame with tx_tready toggled 1/0 every cycle during PAD -> data is held stable while stalled, rx_tready stays 0 in PAD, and the FCS is identical to the unstalled run.
- reset driven low after beat 3 of a 100-byte frame, then a 9-byte frame is sent -> outputs are 0 during reset; the second frame is padded and has the correct FCS, unaffected by the first.
